// File: rtl/bpu_pkg.sv
// Shared types and helpers for the branch-predictor counter table controller.
package bpu_pkg;

  typedef enum logic [1:0] {
    StInit,
    StIdle,
    StUpdWr
  } bpu_state_e;

  localparam logic [1:0] InitValueDefault = 2'b01;

  // 2-bit saturating counter step toward the resolved direction.
  function automatic logic [1:0] sat_update(input logic [1:0] v, input logic taken);
    logic [1:0] r;
    r = v;
    if (taken && (v != 2'b11)) begin
      r = v + 2'd1;
    end else if (!taken && (v != 2'b00)) begin
      r = v - 2'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bpu_table_controller_if.sv
// Fetch lookup, resolve update and counter-table port bundle of the BPU table controller.
interface bpu_table_controller_if #(
  parameter int unsigned ADDR_WIDTH = 6
) ();

  logic                  pred_req;
  logic [ADDR_WIDTH-1:0] pred_addr;
  logic                  pred_gnt;
  logic                  pred_valid;
  logic                  prediction;
  logic                  upd_valid;
  logic [ADDR_WIDTH-1:0] upd_addr;
  logic                  upd_taken;
  logic                  upd_ready;
  logic                  init_done;
  logic                  tbl_en;
  logic                  tbl_we;
  logic [ADDR_WIDTH-1:0] tbl_addr;
  logic [1:0]            tbl_wdata;
  logic [1:0]            tbl_rdata;

  // Environment side: fetch/resolve stages and the table memory.
  modport master (
    output pred_req, pred_addr, upd_valid, upd_addr, upd_taken, tbl_rdata,
    input  pred_gnt, pred_valid, prediction, upd_ready, init_done,
           tbl_en, tbl_we, tbl_addr, tbl_wdata
  );

  // Controller side.
  modport slave (
    input  pred_req, pred_addr, upd_valid, upd_addr, upd_taken, tbl_rdata,
    output pred_gnt, pred_valid, prediction, upd_ready, init_done,
           tbl_en, tbl_we, tbl_addr, tbl_wdata
  );

endinterface

// File: rtl/bpu_upd_fifo.sv
// Update queue for the BPU table controller; power-of-two depth, pointers wrap naturally.
module bpu_upd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCount = DEPTH[PtrW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FullCount);
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/bpu_table_controller.sv
// Arbitrates one single-port 2-bit counter table between fetch lookups and queued updates.
// Optional BPU_STATS_EN adds update/flip counters as extra outputs.
module bpu_table_controller
  import bpu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [1:0]  INIT_VALUE = InitValueDefault
) (
  input  logic                 clk,
  input  logic                 rst,
  bpu_table_controller_if.slave bus
`ifdef BPU_STATS_EN
  ,
  output logic [15:0]          upd_count,
  output logic [15:0]          flip_count
`endif
);

  localparam int unsigned EntW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LastIdx = '1;

  bpu_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_idx_q, init_idx_d;
  logic                  init_done_q, init_done_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic                  wr_taken_q, wr_taken_d;
  logic                  pred_valid_q, pred_hold_q;

  logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [EntW-1:0]       fifo_head;
  logic                  gnt, en, we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [1:0]            wdata;
  logic [1:0]            upd_result;

  assign upd_result = sat_update(bus.tbl_rdata, wr_taken_q);
  assign fifo_push  = bus.upd_valid & bus.upd_ready;

  bpu_upd_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(EntW)
  ) u_upd_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (fifo_push),
    .push_data_i({bus.upd_addr, bus.upd_taken}),
    .pop_i      (fifo_pop),
    .head_o     (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    init_idx_d  = init_idx_q;
    init_done_d = init_done_q;
    wr_addr_d   = wr_addr_q;
    wr_taken_d  = wr_taken_q;
    gnt         = 1'b0;
    en          = 1'b0;
    we          = 1'b0;
    addr        = '0;
    wdata       = '0;
    fifo_pop    = 1'b0;
    unique case (state_q)
      StInit: begin
        en         = 1'b1;
        we         = 1'b1;
        addr       = init_idx_q;
        wdata      = INIT_VALUE;
        init_idx_d = init_idx_q + 1'b1;
        if (init_idx_q == LastIdx) begin
          state_d     = StIdle;
          init_done_d = 1'b1;
        end
      end
      StIdle: begin
        // A full queue outranks lookups so resolve never stalls indefinitely.
        if (fifo_full || (!bus.pred_req && !fifo_empty)) begin
          en         = 1'b1;
          addr       = fifo_head[EntW-1:1];
          fifo_pop   = 1'b1;
          wr_addr_d  = fifo_head[EntW-1:1];
          wr_taken_d = fifo_head[0];
          state_d    = StUpdWr;
        end else if (bus.pred_req) begin
          gnt  = 1'b1;
          en   = 1'b1;
          addr = bus.pred_addr;
        end
      end
      StUpdWr: begin
        en      = 1'b1;
        we      = 1'b1;
        addr    = wr_addr_q;
        wdata   = upd_result;
        state_d = StIdle;
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StInit;
      init_idx_q   <= '0;
      init_done_q  <= 1'b0;
      wr_addr_q    <= '0;
      wr_taken_q   <= 1'b0;
      pred_valid_q <= 1'b0;
      pred_hold_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_idx_q   <= init_idx_d;
      init_done_q  <= init_done_d;
      wr_addr_q    <= wr_addr_d;
      wr_taken_q   <= wr_taken_d;
      pred_valid_q <= gnt;
      if (pred_valid_q) pred_hold_q <= bus.tbl_rdata[1];
    end
  end

  // Outputs are forced idle while rst is high so an in-flight access is aborted.
  assign bus.pred_gnt   = gnt & ~rst;
  assign bus.pred_valid = pred_valid_q & ~rst;
  assign bus.prediction = rst ? 1'b0 : (pred_valid_q ? bus.tbl_rdata[1] : pred_hold_q);
  assign bus.upd_ready  = ~fifo_full & ~rst;
  assign bus.init_done  = init_done_q & ~rst;
  assign bus.tbl_en     = en & ~rst;
  assign bus.tbl_we     = we & ~rst;
  assign bus.tbl_addr   = rst ? '0 : addr;
  assign bus.tbl_wdata  = rst ? '0 : wdata;

`ifdef BPU_STATS_EN
  logic [15:0] upd_count_q, flip_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      upd_count_q  <= '0;
      flip_count_q <= '0;
    end else if (state_q == StUpdWr) begin
      upd_count_q <= upd_count_q + 16'd1;
      if (upd_result[1] != bus.tbl_rdata[1]) flip_count_q <= flip_count_q + 16'd1;
    end
  end

  assign upd_count  = upd_count_q;
  assign flip_count = flip_count_q;
`endif

endmodule

// File: tb/tb_bpu_table_controller.sv
// Randomized bench for bpu_table_controller against a transaction-level table/queue model.
module tb_bpu_table_controller;

  localparam int unsigned AW    = 6;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned N     = 64;
  localparam logic [1:0]  INIT  = 2'b01;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bpu_table_controller_if #(.ADDR_WIDTH(AW)) bus ();

`ifdef BPU_STATS_EN
  logic [15:0] upd_count, flip_count;
`endif

  bpu_table_controller #(
    .ADDR_WIDTH(AW),
    .FIFO_DEPTH(DEPTH),
    .INIT_VALUE(INIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus)
`ifdef BPU_STATS_EN
    ,
    .upd_count (upd_count),
    .flip_count(flip_count)
`endif
  );

  // Table memory: one access per cycle, read data one cycle later.
  logic [1:0] tbl_mem [N];
  logic [1:0] rdata_q;
  always @(posedge clk) begin
    if (bus.tbl_en && bus.tbl_we) tbl_mem[bus.tbl_addr] <= bus.tbl_wdata;
    if (bus.tbl_en && !bus.tbl_we) rdata_q <= tbl_mem[bus.tbl_addr];
  end
  assign bus.tbl_rdata = rdata_q;

  // Reference model state.
  logic [1:0]  ref_tbl [N];
  logic [AW:0] m_q [$];
  bit          m_init, m_done, m_wr, m_wr_taken, m_pv, m_pv_bit, m_hold;
  int          m_idx, m_wr_addr, m_upd_cnt, m_flip_cnt;
  int          n_checks, n_fail;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] next_ctr(input logic [1:0] v, input bit taken);
    int t;
    t = int'(v) + (taken ? 1 : -1);
    if (t > 3) t = 3;
    if (t < 0) t = 0;
    return 2'(t);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_init = 1; m_done = 0; m_wr = 0; m_idx = 0;
    m_pv = 0; m_pv_bit = 0; m_hold = 0;
    m_upd_cnt = 0; m_flip_cnt = 0;
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance the model.
  task automatic step(input bit rq, input int ra, input bit uv, input int ua, input bit ut,
                      input bit r);
    bit          e_gnt, e_en, e_we, e_rd, e_ready;
    int          e_addr;
    logic [1:0]  e_wd, v_old;
    logic [AW:0] ent;
    @(posedge clk);
    #1;
    rst           = r;
    bus.pred_req  = rq;
    bus.pred_addr = AW'(ra);
    bus.upd_valid = uv;
    bus.upd_addr  = AW'(ua);
    bus.upd_taken = ut;
    #1;
    if (r) begin
      check_eq("rst_pred_gnt", bus.pred_gnt, 0);
      check_eq("rst_pred_valid", bus.pred_valid, 0);
      check_eq("rst_prediction", bus.prediction, 0);
      check_eq("rst_init_done", bus.init_done, 0);
      check_eq("rst_tbl_en", bus.tbl_en, 0);
      check_eq("rst_tbl_we", bus.tbl_we, 0);
      check_eq("rst_tbl_addr", bus.tbl_addr, 0);
      check_eq("rst_tbl_wdata", bus.tbl_wdata, 0);
      model_reset();
      return;
    end
    e_ready = (m_q.size() < DEPTH);
    e_gnt = 0; e_en = 0; e_we = 0; e_rd = 0; e_addr = 0; e_wd = '0;
    if (m_init) begin
      e_en = 1; e_we = 1; e_addr = m_idx; e_wd = INIT;
    end else if (m_wr) begin
      e_en = 1; e_we = 1; e_addr = m_wr_addr; e_wd = next_ctr(ref_tbl[m_wr_addr], m_wr_taken);
    end else if (m_q.size() == DEPTH || (!rq && m_q.size() > 0)) begin
      e_rd = 1; e_en = 1; e_addr = int'(m_q[0][AW:1]);
    end else if (rq) begin
      e_gnt = 1; e_en = 1; e_addr = ra;
    end
    check_eq("pred_gnt", bus.pred_gnt, e_gnt);
    check_eq("upd_ready", bus.upd_ready, e_ready);
    check_eq("init_done", bus.init_done, m_done);
    check_eq("tbl_en", bus.tbl_en, e_en);
    if (e_en) begin
      check_eq("tbl_we", bus.tbl_we, e_we);
      check_eq("tbl_addr", bus.tbl_addr, e_addr);
      if (e_we) check_eq("tbl_wdata", bus.tbl_wdata, e_wd);
    end
    check_eq("pred_valid", bus.pred_valid, m_pv);
    check_eq("prediction", bus.prediction, m_pv ? m_pv_bit : m_hold);
    // Advance to the next cycle.
    if (m_pv) m_hold = m_pv_bit;
    m_pv = e_gnt;
    if (e_gnt) m_pv_bit = ref_tbl[ra][1];
    if (m_init) begin
      ref_tbl[m_idx] = INIT;
      m_idx++;
      if (m_idx == N) begin
        m_init = 0;
        m_done = 1;
      end
    end else if (m_wr) begin
      v_old = ref_tbl[m_wr_addr];
      ref_tbl[m_wr_addr] = e_wd;
      m_upd_cnt = (m_upd_cnt + 1) % 65536;
      if (e_wd[1] != v_old[1]) m_flip_cnt = (m_flip_cnt + 1) % 65536;
      m_wr = 0;
    end else if (e_rd) begin
      ent = m_q.pop_front();
      m_wr = 1;
      m_wr_addr = int'(ent[AW:1]);
      m_wr_taken = ent[0];
    end
    if (uv && e_ready) m_q.push_back({AW'(ua), ut});
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int guard;
    logic [1:0] pre;
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    bus.pred_req = 0; bus.pred_addr = '0;
    bus.upd_valid = 0; bus.upd_addr = '0; bus.upd_taken = 0;
    model_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);

    // Init sweep with lookups requested and updates offered (queue fills to full).
    for (int i = 0; i < N; i++)
      step($urandom_range(0, 1), $urandom_range(0, N - 1), i < 6, 20 + i, $urandom_range(0, 1), 0);
    step(0, 0, 0, 0, 0, 0);
    check_eq("init_done_rise", bus.init_done, 1);
    idle(12);

    // Lookup of a freshly initialised entry.
    step(1, 5, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check_eq("lookup5_valid", bus.pred_valid, 1);
    check_eq("lookup5_pred", bus.prediction, 0);

    // Two taken updates then lookup; a third taken update saturates.
    step(0, 0, 1, 5, 1, 0);
    step(0, 0, 1, 5, 1, 0);
    idle(6);
    check_eq("upd5_two", tbl_mem[5], 2'b11);
    step(1, 5, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check_eq("lookup5_taken", bus.prediction, 1);
    step(0, 0, 1, 5, 1, 0);
    idle(4);
    check_eq("upd5_sat", tbl_mem[5], 2'b11);

    // Continuous lookups while updates pile up.
    for (int i = 0; i < 6; i++)
      step(1, $urandom_range(0, 7), 1, $urandom_range(0, 7), $urandom_range(0, 1), 0);
    for (int i = 0; i < 8; i++) step(1, $urandom_range(0, 7), 0, 0, 0, 0);
    idle(12);

    // Push coinciding with a pop at occupancy DEPTH-1.
    for (int i = 0; i < 3; i++)
      step(1, $urandom_range(0, 7), 1, $urandom_range(0, 7), $urandom_range(0, 1), 0);
    step(0, 0, 1, $urandom_range(0, 7), $urandom_range(0, 1), 0);
    step(1, $urandom_range(0, 7), 0, 0, 0, 0);
    idle(12);

    // Random mix with heavy index aliasing.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 9) < 4,
           $urandom_range(0, 7), $urandom_range(0, 1), 0);
    idle(12);
    for (int i = 0; i < N; i++) check_eq("tbl_final", tbl_mem[i], ref_tbl[i]);
`ifdef BPU_STATS_EN
    check_eq("upd_count", upd_count, m_upd_cnt);
    check_eq("flip_count", flip_count, m_flip_cnt);
`endif

    // Reset during an update write with three entries still queued.
    guard = 0;
    while (!(m_wr && m_q.size() == 3) && guard < 20) begin
      step(1, $urandom_range(0, 7), m_q.size() < DEPTH, 40, 1, 0);
      guard++;
    end
    check_eq("rst_setup_reached", guard < 20, 1);
    pre = ref_tbl[40];
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    check_eq("rst_no_write", tbl_mem[40], pre);
`ifdef BPU_STATS_EN
    check_eq("rst_upd_count", upd_count, 0);
    check_eq("rst_flip_count", flip_count, 0);
`endif
    idle(N + 4);
    check_eq("rst_reinit40", tbl_mem[40], INIT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bpu_table_controller.md
BPU_TABLE_CONTROLLER -- requirements
Module: bpu_table_controller

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6, meaning table index width (2**ADDR_WIDTH entries of 2-bit counters).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning update-queue depth (power of two, >=2).
REQ-003 SHALL have parameter INIT_VALUE, default 2'b01, meaning counter value written by the init sweep.
REQ-004 SHALL have ports (name direction width meaning), clock and reset first:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- pred_req  in  1  fetch-stage lookup request.
- pred_addr  in  ADDR_WIDTH  lookup index.
- pred_gnt  out  1  lookup accepted this cycle.
- pred_valid  out  1  prediction valid, one cycle after pred_gnt.
- prediction  out  1  predicted taken (counter MSB).
- upd_valid  in  1  resolve-stage update offered.
- upd_addr  in  ADDR_WIDTH  update index.
- upd_taken  in  1  resolved direction.
- upd_ready  out  1  update queue can accept.
- init_done  out  1  init sweep complete.
- tbl_en  out  1  table port enable.
- tbl_we  out  1  table write enable.
- tbl_addr  out  ADDR_WIDTH  table index.
- tbl_wdata  out  2  write data.
- tbl_rdata  in  2  read data, valid one cycle after a read (tbl_en=1, tbl_we=0).

Function
REQ-005 SHALL own one single-port counter table shared between lookups and updates; one table access per cycle.
REQ-006 SHALL implement states INIT, IDLE, UPD_WR.
REQ-007 INIT: write INIT_VALUE to index 0,1,...,2**ADDR_WIDTH-1, one per cycle; after last index go to IDLE and set init_done=1 (remains 1 until rst).
REQ-008 INIT: pred_gnt=0; upd_ready still follows queue space (updates may be queued).
REQ-009 Update handshake: entry pushed when upd_valid & upd_ready; upd_ready = queue not full.
REQ-010 IDLE arbitration: queue full -> issue update read; else pred_req -> grant lookup; else queue non-empty -> issue update read; else table idle (tbl_en=0).
REQ-011 Lookup: pred_gnt=1 combinationally with the read in the same cycle; next cycle pred_valid=1, prediction=tbl_rdata[1]; otherwise pred_valid=0, prediction holds.
REQ-012 Update read pops queue head, goes to UPD_WR; in UPD_WR write saturating result of tbl_rdata: taken -> min(v+1,3), not taken -> max(v-1,0); then IDLE.
REQ-013 UPD_WR: pred_gnt=0 (lookup stalls one cycle).
REQ-014 Same-cycle push and pop SHALL both occur; pushed entry order preserved (FIFO).
REQ-015 Lookup granted the cycle after UPD_WR to the same index SHALL return the updated value.
REQ-016 Queue pointers wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.

Reset
REQ-017 rst SHALL clear queue, enter INIT at index 0, abort any in-flight access, in any state.
REQ-018 Reset values: pred_gnt 0, pred_valid 0, prediction 0, init_done 0, tbl_en 0, tbl_we 0, tbl_addr 0, tbl_wdata 0; upd_ready 1 from the first cycle after rst deasserts.

Configuration
REQ-019 Macro BPU_STATS_EN: when defined, adds outputs upd_count[15:0] (completed UPD_WR writes) and flip_count[15:0] (writes where counter MSB changed), both reset to 0, wrap at 16'hFFFF->0; when undefined these ports and counters SHALL not exist and behaviour is otherwise identical.

Structure
REQ-020 Package bpu_pkg SHALL hold the state enum, INIT_VALUE default, and the saturating-update function.
REQ-021 Queue SHALL be sub-module bpu_upd_fifo (push/pop/full/empty, data {addr,taken}).

Verification
REQ-022 Reset, ADDR_WIDTH=6 -> 64 writes of 2'b01 to idx 0..63, init_done rises after cycle 64, pred_gnt 0 throughout.
REQ-023 After init, lookup idx 5 -> pred_gnt same cycle, next cycle pred_valid=1, prediction=0.
REQ-024 Two updates idx 5 taken, then lookup idx 5 -> writes 2'b10 then 2'b11, prediction=1; third taken write stays 2'b11.
REQ-025 Continuous pred_req with 4 queued updates -> queue full forces update service; no update lost, upd_ready low only while full.
REQ-026 Push during pop at full-1 occupancy -> occupancy unchanged, FIFO order kept.
REQ-027 rst asserted during UPD_WR with 3 queued -> no write completes, queue empty, INIT restarts at idx 0; with BPU_STATS_EN, counters read 0.
